multi_timer: RTL and testbench

//   Multi-channel programmable timer. Each channel has its own prescaler and supports one-shot, periodic and PWM modes.
//   Per-channel config is double-buffered, and each channel raises a sticky interrupt cleared by acknowledge.

---
 rtl/multi_timer_pkg.sv | 27 ++
 rtl/multi_timer_channel.sv | 156 +++++++++++++++
 rtl/multi_timer.sv | 73 +++++++
 tb/tb_multi_timer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - shared types and helpers for the multi_timer block
// Contents:
//   MODE_W  width of a channel mode field
//   mode_e  ONESHOT / PERIODIC / PWM / RSVD (RSVD behaves as PERIODIC)
//   state_e per-channel run state, IDLE / RUN
//   ch_w()  width of a channel index for a given channel count
package multi_timer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ONESHOT  = 2'd0,
    PERIODIC = 2'd1,
    PWM      = 2'd2,
    RSVD     = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// rtl/multi_timer_channel.sv - one timer channel: FSM, prescaler, counter, shadow config, PWM, irq
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_we                         shadow config write strobe for this channel
//   cfg_mode/period/duty/psc       config values written on cfg_we
//   start, stop, irq_ack           control pulses (stop wins over start)
//   count, busy, pwm_out, irq      live counter, running flag, PWM, sticky interrupt
//   cap_in, cap_val                capture strobe and captured count (MULTI_TIMER_CAPTURE_EN only)
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PSC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic [WIDTH-1:0]  cfg_duty,
  input  logic [PSC_W-1:0]  cfg_psc,
  input  logic              start,
  input  logic              stop,
  input  logic              irq_ack,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              pwm_out,
  output logic              irq
`ifdef MULTI_TIMER_CAPTURE_EN
  ,
  input  logic              cap_in,
  output logic [WIDTH-1:0]  cap_val
`endif
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PSC_W-1:0]   psc_cnt_q, psc_cnt_d;
  mode_e              act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
  logic [WIDTH-1:0]   act_period_q, act_period_d, sh_period_q, sh_period_d;
  logic [WIDTH-1:0]   act_duty_q, act_duty_d, sh_duty_q, sh_duty_d;
  logic [PSC_W-1:0]   act_psc_q, act_psc_d, sh_psc_q, sh_psc_d;
  logic               pwm_q, pwm_d;
  logic               irq_q, irq_d;
  logic               tick, term, load;

  always_comb begin
    // A write in the same cycle as a load is forwarded straight to active.
    sh_mode_d    = cfg_we ? mode_e'(cfg_mode) : sh_mode_q;
    sh_period_d  = cfg_we ? cfg_period : sh_period_q;
    sh_duty_d    = cfg_we ? cfg_duty   : sh_duty_q;
    sh_psc_d     = cfg_we ? cfg_psc    : sh_psc_q;

    state_d      = state_q;
    count_d      = count_q;
    psc_cnt_d    = psc_cnt_q;
    act_mode_d   = act_mode_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_psc_d    = act_psc_q;
    load         = 1'b0;

    tick = (state_q == RUN) && (psc_cnt_q == act_psc_q);
    term = tick && (count_q == act_period_q);

    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d   = RUN;
      count_d   = '0;
      psc_cnt_d = '0;
      load      = 1'b1;
    end else if (state_q == RUN) begin
      if (tick) begin
        psc_cnt_d = '0;
        if (term) begin
          load = 1'b1;
          // One-shot holds count at period; the other modes wrap to zero.
          if (act_mode_q == ONESHOT) state_d = IDLE;
          else                       count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        psc_cnt_d = psc_cnt_q + 1'b1;
      end
    end

    if (load || (state_q == IDLE && cfg_we)) begin
      act_mode_d   = sh_mode_d;
      act_period_d = sh_period_d;
      act_duty_d   = sh_duty_d;
      act_psc_d    = sh_psc_d;
    end

    // Set wins over acknowledge.
    irq_d = irq_q;
    if (term)         irq_d = 1'b1;
    else if (irq_ack) irq_d = 1'b0;

    // Computed from next-state values so the registered output lines up with count.
    pwm_d = (state_d == RUN) && (act_mode_d == PWM) && (count_d < act_duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      psc_cnt_q    <= '0;
      act_mode_q   <= ONESHOT;
      act_period_q <= '0;
      act_duty_q   <= '0;
      act_psc_q    <= '0;
      sh_mode_q    <= ONESHOT;
      sh_period_q  <= '0;
      sh_duty_q    <= '0;
      sh_psc_q     <= '0;
      pwm_q        <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      psc_cnt_q    <= psc_cnt_d;
      act_mode_q   <= act_mode_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_psc_q    <= act_psc_d;
      sh_mode_q    <= sh_mode_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_psc_q     <= sh_psc_d;
      pwm_q        <= pwm_d;
      irq_q        <= irq_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign pwm_out = pwm_q;
  assign irq     = irq_q;

`ifdef MULTI_TIMER_CAPTURE_EN
  logic cap_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dly_q <= 1'b0;
      cap_val   <= '0;
    end else begin
      cap_dly_q <= cap_in;
      if (cap_in && !cap_dly_q) cap_val <= count_q;
    end
  end
`endif

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - multi-channel programmable timer bank (one-shot, periodic, PWM)
// Optional feature: define MULTI_TIMER_CAPTURE_EN for per-channel input capture.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   cfg_we, cfg_ch     config write strobe and target channel (out-of-range writes ignored)
//   cfg_mode/period/duty/psc  config payload
//   start, stop, irq_ack      per-channel control pulses
//   count              live counters, channel i at [i*WIDTH +: WIDTH]
//   busy, pwm_out, irq per-channel running flag, PWM waveform, sticky interrupt
//   cap_in, cap_val    capture strobes and captured counts (MULTI_TIMER_CAPTURE_EN only)
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int PSC_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
  input  logic [MODE_W-1:0]       cfg_mode,
  input  logic [WIDTH-1:0]        cfg_period,
  input  logic [WIDTH-1:0]        cfg_duty,
  input  logic [PSC_W-1:0]        cfg_psc,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH-1:0]       irq
`ifdef MULTI_TIMER_CAPTURE_EN
  ,
  input  logic [NUM_CH-1:0]       cap_in,
  output logic [NUM_CH*WIDTH-1:0] cap_val
`endif
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0] we_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we_ch[i] = cfg_we && (cfg_ch == CH_W'(i));

    multi_timer_channel #(
      .WIDTH (WIDTH),
      .PSC_W (PSC_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (we_ch[i]),
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .cfg_psc    (cfg_psc),
      .start      (start[i]),
      .stop       (stop[i]),
      .irq_ack    (irq_ack[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .busy       (busy[i]),
      .pwm_out    (pwm_out[i]),
      .irq        (irq[i])
`ifdef MULTI_TIMER_CAPTURE_EN
      ,
      .cap_in     (cap_in[i]),
      .cap_val    (cap_val[i*WIDTH +: WIDTH])
`endif
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer
module tb_multi_timer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [1:0]   cfg_mode;
  logic [31:0]  cfg_period;
  logic [31:0]  cfg_duty;
  logic [7:0]   cfg_psc;
  logic [3:0]   start;
  logic [3:0]   stop;
  logic [3:0]   irq_ack;
  logic [127:0] count;
  logic [3:0]   busy;
  logic [3:0]   pwm_out;
  logic [3:0]   irq;
`ifdef MULTI_TIMER_CAPTURE_EN
  logic [3:0]   cap_in;
  logic [127:0] cap_val;
`endif

  int checks = 0;
  int errors = 0;
  int hi;

  always #5 clk = ~clk;

  multi_timer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_psc    (cfg_psc),
    .start      (start),
    .stop       (stop),
    .irq_ack    (irq_ack),
    .count      (count),
    .busy       (busy),
    .pwm_out    (pwm_out),
    .irq        (irq)
`ifdef MULTI_TIMER_CAPTURE_EN
    ,
    .cap_in     (cap_in),
    .cap_val    (cap_val)
`endif
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [31:0] period, input logic [31:0] duty,
                           input logic [7:0] psc);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode;
    cfg_period = period; cfg_duty = duty; cfg_psc = psc;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start = m;
    cyc(1);
    start = '0;
  endtask

  task automatic ack(input logic [3:0] m);
    irq_ack = m;
    cyc(1);
    irq_ack = '0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_duty = '0; cfg_psc = '0;
    start = '0; stop = '0; irq_ack = '0;
`ifdef MULTI_TIMER_CAPTURE_EN
    cap_in = '0;
`endif
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Reset state
    chk("rst_count", count, 128'd0);
    chk("rst_busy", {124'd0, busy}, 128'd0);
    chk("rst_irq", {124'd0, irq}, 128'd0);
    chk("rst_pwm", {124'd0, pwm_out}, 128'd0);

    // 1: ch0 one-shot, period 5, psc 0 -> irq 6 edges after start
    cfg_write(2'd0, 2'd0, 32'd5, 32'd0, 8'd0);
    pulse_start(4'b0001);
    chk("os_busy_start", {127'd0, busy[0]}, 128'd1);
    chk("os_count_start", {96'd0, count[31:0]}, 128'd0);
    cyc(5);
    chk("os_irq_early", {127'd0, irq[0]}, 128'd0);
    chk("os_count5", {96'd0, count[31:0]}, 128'd5);
    cyc(1);
    chk("os_irq", {127'd0, irq[0]}, 128'd1);
    chk("os_busy_drop", {127'd0, busy[0]}, 128'd0);
    cyc(3);
    chk("os_count_hold", {96'd0, count[31:0]}, 128'd5);
    ack(4'b0001);
    chk("os_ack", {127'd0, irq[0]}, 128'd0);

    // 2: ch1 periodic, period 3, psc 2 -> event every 12 cycles
    cfg_write(2'd1, 2'd1, 32'd3, 32'd0, 8'd2);
    pulse_start(4'b0010);
    cyc(11);
    chk("per_irq_e11", {127'd0, irq[1]}, 128'd0);
    cyc(1);
    chk("per_irq_e12", {127'd0, irq[1]}, 128'd1);
    chk("per_count_wrap", {96'd0, count[63:32]}, 128'd0);
    ack(4'b0010);
    chk("per_ack1", {127'd0, irq[1]}, 128'd0);
    cyc(10);
    chk("per_irq_e23", {127'd0, irq[1]}, 128'd0);
    cyc(1);
    chk("per_irq_e24", {127'd0, irq[1]}, 128'd1);
    ack(4'b0010);
    chk("per_ack2", {127'd0, irq[1]}, 128'd0);

    // 4: running ch1 reprogrammed to period 7; current cycle keeps period 3
    cfg_write(2'd1, 2'd1, 32'd7, 32'd0, 8'd2);
    cyc(9);
    chk("shadow_e35", {127'd0, irq[1]}, 128'd0);
    cyc(1);
    chk("shadow_e36", {127'd0, irq[1]}, 128'd1);
    ack(4'b0010);
    cyc(22);
    chk("shadow_e59", {127'd0, irq[1]}, 128'd0);
    cyc(1);
    chk("shadow_e60", {127'd0, irq[1]}, 128'd1);
    ack(4'b0010);
    start = 4'b0010; stop = 4'b0010;
    cyc(1);
    start = '0; stop = '0;
    chk("start_stop_idle", {127'd0, busy[1]}, 128'd0);

    // 3: ch2 PWM, period 9, duty 3 -> high 3 of 10
    cfg_write(2'd2, 2'd2, 32'd9, 32'd3, 8'd0);
    pulse_start(4'b0100);
    chk("pwm_first", {127'd0, pwm_out[2]}, 128'd1);
    hi = 0;
    for (int k = 0; k < 10; k++) begin hi += int'(pwm_out[2]); cyc(1); end
    chk("pwm_d3_hi", 128'(hi), 128'd3);
    cfg_write(2'd2, 2'd2, 32'd9, 32'd0, 8'd0);
    pulse_start(4'b0100);
    hi = 0;
    for (int k = 0; k < 20; k++) begin hi += int'(pwm_out[2]); cyc(1); end
    chk("pwm_d0_hi", 128'(hi), 128'd0);
    cfg_write(2'd2, 2'd2, 32'd9, 32'd15, 8'd0);
    pulse_start(4'b0100);
    hi = 0;
    for (int k = 0; k < 20; k++) begin hi += int'(pwm_out[2]); cyc(1); end
    chk("pwm_d15_hi", 128'(hi), 128'd20);
    stop = 4'b0100;
    cyc(1);
    stop = '0;
    chk("pwm_stop_busy", {127'd0, busy[2]}, 128'd0);
    chk("pwm_stop_out", {127'd0, pwm_out[2]}, 128'd0);

    // 5: ch3 periodic period 1 -> events on edges 2, 4, 6...; ack on edge 4
    cfg_write(2'd3, 2'd1, 32'd1, 32'd0, 8'd0);
    pulse_start(4'b1000);
    cyc(3);
    chk("coinc_pre", {127'd0, irq[3]}, 128'd1);
    ack(4'b1000);
    chk("coinc_set_wins", {127'd0, irq[3]}, 128'd1);
    ack(4'b1000);
    chk("coinc_plain_ack", {127'd0, irq[3]}, 128'd0);
    stop = 4'b1000;
    cyc(1);
    stop = '0;

    // ch3 periodic period 100 for capture and mid-run reset
    cfg_write(2'd3, 2'd1, 32'd100, 32'd0, 8'd0);
    pulse_start(4'b1000);
    cyc(42);
    chk("cnt3_42", {96'd0, count[127:96]}, 128'd42);
`ifdef MULTI_TIMER_CAPTURE_EN
    cap_in = 4'b1000;
    cyc(1);
    chk("cap_42", {96'd0, cap_val[127:96]}, 128'd42);
    cyc(5);
    chk("cap_hold", {96'd0, cap_val[127:96]}, 128'd42);
    cap_in = '0;
`endif
    chk("busy3_before_rst", {127'd0, busy[3]}, 128'd1);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 128'd0);
    chk("arst_busy", {124'd0, busy}, 128'd0);
    chk("arst_irq", {124'd0, irq}, 128'd0);
    chk("arst_pwm", {124'd0, pwm_out}, 128'd0);
`ifdef MULTI_TIMER_CAPTURE_EN
    chk("arst_cap", cap_val, 128'd0);
`endif
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Reset config is one-shot period 0: irq one edge after start
    pulse_start(4'b0001);
    chk("rstcfg_busy", {127'd0, busy[0]}, 128'd1);
    cyc(1);
    chk("rstcfg_irq", {127'd0, irq[0]}, 128'd1);
    chk("rstcfg_idle", {127'd0, busy[0]}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
